// File: rtl/capture_pkg.sv
// Shared types and default sizing for the signal capture monitor.
// CAPTURE_TIMESTAMP_EN adds a timestamp field to each log entry.
package capture_pkg;

    localparam int CAP_WIDTH = 3;
    localparam int CAP_DEPTH = 8;
    localparam int CAP_TS_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BASE    = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    // Entry layout at the default sizing; the top rebuilds it from its own parameters.
    typedef struct packed {
`ifdef CAPTURE_TIMESTAMP_EN
        logic [CAP_TS_W-1:0]  ts;
`endif
        logic [CAP_WIDTH-1:0] value;
    } cap_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO holding entries of type T, DEPTH a power of two.
// Latency: a push at edge N is visible at the head after edge N; head is combinational.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wr_dat,
    output T                       rd_dat,
    output logic                   rd_vld,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign rd_vld  = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && rd_vld;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_dat;
    end

    // Storage is not reset, so the head is masked while empty.
    assign rd_dat = rd_vld ? mem[rd_ptr] : T'('0);

endmodule

// File: rtl/signal_capture_monitor.sv
// Logs every value change of in_sig into a FIFO and keeps a sticky map of patterns seen.
// Latency: a change sampled at edge N is at the read port after edge N (macro CAPTURE_TIMESTAMP_EN adds rd_ts).
// Backpressure: changes arriving while the FIFO is full are dropped and flag overflow.
module signal_capture_monitor
    import capture_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH,
    parameter int DEPTH = CAP_DEPTH,
    parameter int TS_W  = CAP_TS_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       in_sig,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
`ifdef CAPTURE_TIMESTAMP_EN
    output logic [TS_W-1:0]        rd_ts,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [2**WIDTH-1:0]    seen_mask,
    output logic                   all_seen
);

    typedef struct packed {
`ifdef CAPTURE_TIMESTAMP_EN
        logic [TS_W-1:0]  ts;
`endif
        logic [WIDTH-1:0] value;
    } entry_t;

    cap_state_t       state_q;
    cap_state_t       state_d;
    logic [WIDTH-1:0] prev_q;
    logic             sampling;
    logic             push_req;
    logic             pop_req;
    entry_t           wr_entry;
    entry_t           head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = IDLE;
        end else if (clear) begin
            state_d = BASE;
        end else begin
            case (state_q)
                IDLE:    state_d = BASE;
                BASE:    state_d = CAPTURE;
                default: state_d = CAPTURE;
            endcase
        end
    end

    // clear wins over sampling, so the cycle it is pulsed neither logs nor marks.
    assign sampling = arm && !clear && (state_q != IDLE);
    assign push_req = sampling && ((state_q == BASE) || (in_sig != prev_q));
    assign pop_req  = rd_en && rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            overflow  <= 1'b0;
            seen_mask <= '0;
        end else if (clear) begin
            overflow  <= 1'b0;
            seen_mask <= '0;
        end else begin
            if (sampling) begin
                prev_q            <= in_sig;
                seen_mask[in_sig] <= 1'b1;
            end
            if (push_req && full && !pop_req) overflow <= 1'b1;
        end
    end

    assign all_seen       = &seen_mask;
    assign wr_entry.value = in_sig;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Restarting on every entry into BASE gives the baseline entry ts = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     ts_q <= '0;
        else if (state_d == BASE)       ts_q <= '0;
        else if (arm && (ts_q != '1))   ts_q <= ts_q + 1'b1;
    end

    assign wr_entry.ts = ts_q;
    assign rd_ts       = head.ts;
`endif

    sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .push   (push_req),
        .pop    (pop_req),
        .wr_dat (wr_entry),
        .rd_dat (head),
        .rd_vld (rd_valid),
        .count  (count),
        .full   (full)
    );

    assign rd_data = head.value;

endmodule

// File: tb/tb_signal_capture_monitor.sv
// Directed bench for signal_capture_monitor with a queue-based model checked every cycle.
module tb_signal_capture_monitor;

    localparam int W   = 3;
    localparam int D   = 8;
    localparam int TSW = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         arm   = 1'b0;
    logic         clear = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] in_sig = '0;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic [3:0]   count;
    logic         full;
    logic         overflow;
    logic [7:0]   seen_mask;
    logic         all_seen;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [TSW-1:0] rd_ts;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    signal_capture_monitor #(.WIDTH(W), .DEPTH(D), .TS_W(TSW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .clear     (clear),
        .in_sig    (in_sig),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
`ifdef CAPTURE_TIMESTAMP_EN
        .rd_ts     (rd_ts),
`endif
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .seen_mask (seen_mask),
        .all_seen  (all_seen)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: the log is a queue; m_run counts consecutive armed edges of the current run
    // (first edge only arms, second takes the baseline, later ones log changes).
    logic [W-1:0] m_val[$];
    int           m_ts[$];
    logic         m_ovf;
    logic [7:0]   m_seen;
    int           m_run;
    logic [W-1:0] m_prev;
    int           cyc;
    int           m_base;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val.delete();
            m_ts.delete();
            m_ovf  = 1'b0;
            m_seen = '0;
            m_run  = 0;
            m_prev = '0;
            cyc    = 0;
            m_base = 0;
        end else begin
            cyc++;
            if (clear) begin
                m_val.delete();
                m_ts.delete();
                m_ovf  = 1'b0;
                m_seen = '0;
                m_run  = arm ? 1 : 0;
            end else begin
                if (rd_en && m_val.size() > 0) begin
                    void'(m_val.pop_front());
                    void'(m_ts.pop_front());
                end
                if (arm && m_run >= 1) begin
                    m_seen[in_sig] = 1'b1;
                    if (m_run == 1 || in_sig != m_prev) begin
                        if (m_run == 1) m_base = cyc;
                        if (m_val.size() < D) begin
                            m_val.push_back(in_sig);
                            m_ts.push_back((cyc - m_base) > 65535 ? 65535 : (cyc - m_base));
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    m_prev = in_sig;
                end
                m_run = arm ? ((m_run < 2) ? m_run + 1 : 2) : 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_valid",  32'(rd_valid),  32'(m_val.size() > 0));
        chk("rd_data",   32'(rd_data),   (m_val.size() > 0) ? 32'(m_val[0]) : 32'd0);
        chk("count",     32'(count),     32'(m_val.size()));
        chk("full",      32'(full),      32'(m_val.size() == D));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("seen_mask", 32'(seen_mask), 32'(m_seen));
        chk("all_seen",  32'(all_seen),  32'(&m_seen));
`ifdef CAPTURE_TIMESTAMP_EN
        chk("rd_ts",     32'(rd_ts),     (m_ts.size() > 0) ? 32'(m_ts[0]) : 32'd0);
`endif
    end

    logic [W-1:0] got[$];
    int           got_ts[$];

    // Pops until empty; exp_list holds one hex digit per expected value, oldest first.
    task automatic drain_and_check(input string tag, input logic [63:0] exp_list, input int n);
        logic [63:0] lst;
        got.delete();
        got_ts.delete();
        for (int i = 0; i < 2 * D && rd_valid; i++) begin
            got.push_back(rd_data);
`ifdef CAPTURE_TIMESTAMP_EN
            got_ts.push_back(int'(rd_ts));
`endif
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        lst = exp_list;
        chk({tag, "_len"}, 32'(got.size()), 32'(n));
        chk({tag, "_empty"}, 32'(rd_valid), 32'd0);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(lst[4*(n-1-i) +: 3]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pats [6];
        pats = '{3'b000, 3'b111, 3'b011, 3'b100, 3'b101, 3'b010};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Disarmed: nothing logged or marked.
        for (int i = 0; i < 5; i++) begin
            in_sig = W'(i * 5);
            @(negedge clk);
        end
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_seen", 32'(seen_mask), 32'd0);
        chk("idle_valid", 32'(rd_valid), 32'd0);

        // Six patterns held two cycles each.
        arm = 1'b1;
        in_sig = '0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            in_sig = pats[i];
            repeat (2) @(negedge clk);
        end
        chk("seq_seen", 32'(seen_mask), 32'h0BD);
        chk("seq_all_seen", 32'(all_seen), 32'd0);
        drain_and_check("seq", 64'h073452, 6);
`ifdef CAPTURE_TIMESTAMP_EN
        for (int i = 0; i < 6 && i < got_ts.size(); i++)
            chk($sformatf("seq_ts_%0d", i), 32'(got_ts[i]), 32'(2 * i));
`endif

        // Baseline plus ten alternating changes with no reads.
        clear = 1'b1; in_sig = 3'b000;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            in_sig = (i % 2 == 0) ? 3'b101 : 3'b010;
            @(negedge clk);
        end
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain_and_check("ovf", 64'h05252525, 8);

        // Exactly full, then a change together with a pop.
        clear = 1'b1; in_sig = 3'b000;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            in_sig = (i % 2 == 0) ? 3'b101 : 3'b010;
            @(negedge clk);
        end
        chk("fill_count", 32'(count), 32'd8);
        in_sig = 3'b010;
        rd_en  = 1'b1;
        @(negedge clk);
        rd_en  = 1'b0;
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(rd_data), 32'd5);
        drain_and_check("pp", 64'h52525252, 8);

        // All eight patterns, then clear with a change pending.
        clear = 1'b1; in_sig = 3'b000;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        for (int v = 1; v < 8; v++) begin
            in_sig = W'(v);
            @(negedge clk);
        end
        chk("all_seen1", 32'(all_seen), 32'd1);
        clear = 1'b1; in_sig = 3'b011;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_seen", 32'(seen_mask), 32'd0);
        @(negedge clk);
        chk("clr_base_count", 32'(count), 32'd1);
        chk("clr_base_data", 32'(rd_data), 32'd3);
        chk("clr_base_seen", 32'(seen_mask), 32'h08);

        // Asynchronous reset between edges while capturing.
        in_sig = 3'b110;
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_seen", 32'(seen_mask), 32'd0);
        chk("rst_all", 32'(all_seen), 32'd0);
        arm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        arm = 1'b1; in_sig = 3'b110;
        repeat (2) @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_data", 32'(rd_data), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
